// File: rtl/arb_mux.sv
`default_nettype none
// arb_mux: N-way request arbiter (round-robin or fixed priority) feeding a
// one-entry registered output slot with valid/ready handshake on both sides.
module arb_mux #(
    parameter int N         = 5,
    parameter int W         = 1,
    parameter int FIXED_PRI = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*W-1:0]       in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_ch,
    input  logic                 out_ready
);
    localparam int CW = $clog2(N);

    logic [CW-1:0] lptr;
    logic [CW-1:0] grant_ch;
    logic [CW-1:0] scan_idx;
    logic          found;
    logic          slot_free;
    logic          grant;
    logic [W-1:0]  sel_data;

    assign slot_free = !out_valid || out_ready;
    // Reset gate keeps in_ready low while reset_n is held, even though the
    // cleared output slot would otherwise look free.
    assign grant     = slot_free && found && reset_n;

    always_comb begin
        grant_ch = '0;
        found    = 1'b0;
        scan_idx = lptr;
        if (FIXED_PRI != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant_ch = CW'(i);
                    found    = 1'b1;
                end
            end
        end else begin
            // Walk lptr+1, lptr+2, ... with explicit wrap at N-1.
            for (int k = 0; k < N; k++) begin
                scan_idx = (scan_idx == CW'(N - 1)) ? '0 : scan_idx + CW'(1);
                if (!found && in_valid[scan_idx]) begin
                    grant_ch = scan_idx;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_ch == CW'(i)) begin
                sel_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (grant) begin
            in_ready = {{(N-1){1'b0}}, 1'b1} << grant_ch;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            lptr      <= CW'(N - 1);
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant_ch;
            lptr      <= grant_ch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// tb_arb_mux: scoreboard bench for a round-robin and a fixed-priority arb_mux
// (N=5, W=8) driven side by side from a shared clock and reset.
module tb_arb_mux;
    logic        clk;
    logic        reset_n;
    logic [4:0]  iv   [2];
    logic [39:0] id   [2];
    logic [4:0]  ir   [2];
    logic        ov   [2];
    logic [7:0]  od   [2];
    logic [2:0]  och  [2];
    logic        ordy [2];

    int checks   = 0;
    int failures = 0;

    // Reference state kept by the bench
    bit          m_ov   [2];
    int          m_lptr [2];
    logic [10:0] q0[$];
    logic [10:0] q1[$];

    arb_mux #(.N(5), .W(8), .FIXED_PRI(0)) u_rr (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_data(id[0]),
        .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ch(och[0]),
        .out_ready(ordy[0])
    );

    arb_mux #(.N(5), .W(8), .FIXED_PRI(1)) u_fp (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_data(id[1]),
        .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ch(och[1]),
        .out_ready(ordy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [4:0] v, input int lp, input bit fixed);
        if (v == 5'b0) return -1;
        if (fixed) begin
            for (int i = 0; i < 5; i++) if (v[i]) return i;
        end
        for (int k = 1; k <= 5; k++) if (v[(lp + k) % 5]) return (lp + k) % 5;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ov[d]   = 1'b0;
            m_lptr[d] = 4;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic check_dut(input int d);
        int          g;
        bit          gr;
        logic [4:0]  mask;
        logic [10:0] e;
        logic [39:0] dv;
        bit          empty;
        g    = pick(iv[d], m_lptr[d], d == 1);
        gr   = (!m_ov[d] || ordy[d]) && (g >= 0);
        mask = gr ? 5'(1 << g) : 5'b0;
        check(d == 0 ? "rr_in_ready" : "fp_in_ready", 32'(ir[d]), 32'(mask));
        check("in_ready_onehot0", 32'($onehot0(ir[d])), 32'd1);
        check(d == 0 ? "rr_out_valid" : "fp_out_valid", 32'(ov[d]), 32'(m_ov[d]));
        if (ov[d] && ordy[d]) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                check("sb_word_expected", 32'd0, 32'd1);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check(d == 0 ? "rr_out_word" : "fp_out_word", {21'd0, och[d], od[d]}, {21'd0, e});
            end
        end
        if (gr) begin
            dv = id[d] >> (g * 8);
            e  = {3'(g), dv[7:0]};
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            m_ov[d]   = 1'b1;
            m_lptr[d] = g;
        end else if (ordy[d]) begin
            m_ov[d] = 1'b0;
        end
    endtask

    // Inputs are set just after a falling edge; checks run 1 time unit later.
    task automatic tick();
        #1;
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] v, input logic r);
        for (int d = 0; d < 2; d++) begin
            iv[d]   = v;
            ordy[d] = r;
            id[d]   = {$urandom(), 8'($urandom())};
        end
    endtask

    initial begin
        int exp_rr [5] = '{0, 2, 4, 0, 2};
        reset_n = 1'b0;
        drive(5'b11111, 1'b1);
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_out_valid", 32'(ov[d]), 32'd0);
            check("reset_out_data", 32'(od[d]), 32'd0);
            check("reset_out_ch", 32'(och[d]), 32'd0);
            check("reset_in_ready", 32'(ir[d]), 32'd0);
        end
        reset_n = 1'b1;

        // Round-robin over 10101 from reset favours channel 0 first
        for (int k = 0; k < 5; k++) begin
            drive(5'b10101, 1'b1);
            #1 check("rr_sequence", 32'(ir[0]), 32'(1 << exp_rr[k]));
            tick();
        end

        // Fixed priority with 11000 always picks channel 3
        for (int k = 0; k < 6; k++) begin
            drive(5'b11000, 1'b1);
            #1 check("fp_ch3_only", 32'(ir[1]), 32'b01000);
            tick();
        end

        // Backpressure while holding A5 from channel 2
        drive(5'b00100, 1'b1);
        id[0][23:16] = 8'hA5;
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(5'b11111, 1'b0);
            #1;
            check("bp_in_ready", 32'(ir[0]), 32'd0);
            check("bp_out_data", 32'(od[0]), 32'hA5);
            check("bp_out_ch", 32'(och[0]), 32'd2);
            tick();
        end
        drive(5'b11111, 1'b1);
        #1 check("bp_release_grant", 32'(ir[0]), 32'b01000);
        tick();

        // Wrap-around search from lptr=4
        drive(5'b10000, 1'b1);
        tick();
        drive(5'b00010, 1'b1);
        #1 check("wrap_grant_1", 32'(ir[0]), 32'b00010);
        tick();
        drive(5'b00110, 1'b1);
        #1 check("lptr_now_1", 32'(ir[0]), 32'b00100);
        tick();

        // Asynchronous reset between edges while a word is held
        drive(5'b00000, 1'b0);
        tick();
        check("pre_reset_valid", 32'(ov[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("async_out_valid", 32'(ov[d]), 32'd0);
            check("async_out_data", 32'(od[d]), 32'd0);
            check("async_out_ch", 32'(och[d]), 32'd0);
            check("async_in_ready", 32'(ir[d]), 32'd0);
        end
        #1 reset_n = 1'b1;
        model_reset();
        drive(5'b10110, 1'b1);
        #1;
        check("post_reset_rr", 32'(ir[0]), 32'b00010);
        check("post_reset_fp", 32'(ir[1]), 32'b00010);
        tick();

        // Random traffic
        for (int k = 0; k < 10000; k++) begin
            drive(5'($urandom()), 1'($urandom_range(0, 3) != 0));
            tick();
        end

        // Drain so every accepted word must have come out
        for (int k = 0; k < 3; k++) begin
            drive(5'b00000, 1'b1);
            tick();
        end
        check("rr_sb_drained", 32'(q0.size()), 32'd0);
        check("fp_sb_drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter N, default 5, number of input channels (2..16).
REQ-002 SHALL have parameter W, default 1, data width per channel (1..32).
REQ-003 SHALL have parameter FIXED_PRI, default 0; 0 = round-robin arbitration, 1 = fixed priority with lowest index winning.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  N  bit i high = channel i offers data.
REQ-007 SHALL have port in_data  input  N*W  channel i data at bits [i*W+W-1 : i*W].
REQ-008 SHALL have port in_ready  output  N  bit i high = channel i accepted this cycle; at most one bit high.
REQ-009 SHALL have port out_valid  output  1  output register holds a word.
REQ-010 SHALL have port out_data  output  W  registered selected data.
REQ-011 SHALL have port out_ch  output  $clog2(N)  index of the channel that produced out_data.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-013 SHALL contain a one-entry output register (out_valid, out_data, out_ch) and a last-grant pointer lptr of $clog2(N) bits; no other storage.
REQ-014 SHALL define the output slot free as (!out_valid | out_ready).
REQ-015 SHALL, when the slot is free and any in_valid bit is high, grant exactly one channel g in the same cycle: in_ready[g]=1 and all other bits 0.
REQ-016 SHALL drive in_ready to all zeros when the slot is not free or no in_valid bit is high.
REQ-017 SHALL, for FIXED_PRI=0, choose g as the first requesting index found by searching lptr+1, lptr+2, ... modulo N; the search wraps from N-1 to 0.
REQ-018 SHALL, for FIXED_PRI=1, choose g as the lowest requesting index and ignore lptr.
REQ-019 SHALL update lptr to g only on a grant edge; otherwise lptr holds.
REQ-020 SHALL, on a grant edge, load out_data = in_data[g], out_ch = g and out_valid = 1; latency from acceptance to out_valid is 1 cycle.
REQ-021 SHALL, on an edge with out_valid & out_ready and no grant, clear out_valid and hold out_data and out_ch.
REQ-022 SHALL hold out_data and out_ch stable while out_valid=1 and out_ready=0 (backpressure); in_ready is 0 during this time.
REQ-023 SHALL sustain one word per cycle when out_ready is held high and requests are continuous (drain and refill on the same edge).
REQ-024 SHALL never drop or duplicate a word: each in_valid&in_ready handshake produces exactly one out_valid&out_ready handshake, in grant order.
REQ-025 SHALL treat in_data as don't-care for non-granted channels; an in_valid deassertion without a grant has no effect.
REQ-026 SHALL, with N=5, W=1, FIXED_PRI=1 and out_ready=1, present d[s] for the lowest asserted request, giving the 5-way selection behaviour of the earlier combinational switch with registered output and handshake.

Reset
REQ-027 SHALL, on reset_n low and independent of clk, force out_valid=0, out_data=0, out_ch=0 and lptr=N-1, so that round-robin favours channel 0 first.
REQ-028 SHALL keep in_ready at all zeros while reset_n is low.
REQ-029 SHALL discard any word held in the output register when reset is asserted mid-operation, with no output handshake for it.
REQ-030 SHALL grant on the first rising edge after reset_n deasserts, given a request.

Verification
REQ-031 SHALL be checked with: reset, then N=5, in_valid=5'b10101, out_ready=1 held, FIXED_PRI=0 -> grants 0,2,4,0,2 on consecutive cycles; out_ch follows one cycle later.
REQ-032 SHALL be checked with: FIXED_PRI=1, in_valid=5'b11000 held, out_ready=1 -> every grant goes to channel 3 and channel 4 never gets in_ready.
REQ-033 SHALL be checked with: out_valid=1 carrying data 8'hA5 from ch 2, out_ready=0 for 4 cycles and requests pending -> in_ready=0 and out_data=8'hA5, out_ch=2 stable; on out_ready=1 a new grant loads on the same edge.
REQ-034 SHALL be checked with: lptr=4 and only in_valid[1]=1 -> wrap-around search grants channel 1 and lptr becomes 1.
REQ-035 SHALL be checked with: reset_n pulsed low between edges while out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately; the next grant after release goes to the lowest requesting index at or above 0.
REQ-036 SHALL be checked with: a random scoreboard run with random in_valid and out_ready over 10k cycles -> outputs are in order, with no loss or duplication, and at most one in_ready bit is high in any cycle.
